// File: rtl/uart_pkg.sv
// Shared UART types: parity modes and receiver FSM states, plus the parity check
// used by both directions.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // data_xor is the XOR of all data bits; odd parity wants data^p == 1
  function automatic logic par_mismatch(input parity_e mode, input logic data_xor,
                                        input logic par_bit);
    logic r;
    case (mode)
      PAR_EVEN: r = data_xor ^ par_bit;
      PAR_ODD:  r = ~(data_xor ^ par_bit);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_baud_tick_gen.sv
// Free-running baud tick: one-clk pulse every cfg_div+1 clocks.
module baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  // >= so a divisor lowered below the current count still wraps promptly
  assign w_hit = (r_cnt >= cfg_div);
  assign tick  = w_hit;

  // divisor counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (DBIT data, none/even/odd parity, 1/2 stop)
// with a one-frame valid/ready holding register and overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int OVS   = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             rx,
  output logic [DBIT-1:0]  rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break,
  output logic             rx_overrun
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  logic            r_rx_meta, r_rx_sync;
  logic            w_tick;
  rx_state_e       r_state, w_next;
  logic [TW-1:0]   r_tcnt;
  logic [BW-1:0]   r_bcnt;
  logic [DBIT-1:0] r_shift;
  logic            r_par_bit, r_stop2, r_stop_idx, r_stop_err, r_all_zero;
  parity_e         r_par_mode;
  logic            w_sample, w_done, w_frame_err, w_break, w_par_err;
  logic [DBIT-1:0] r_data;
  logic            r_valid, r_perr, r_ferr, r_brk, r_ovr;

  baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (!r_rx_sync) w_next = ST_START;
      ST_START:     if (w_sample) w_next = r_rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_sample && r_bcnt == BIT_LAST)
                      w_next = (r_par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY:    if (w_sample) w_next = ST_STOP;
      ST_STOP:      if (w_done) w_next = r_rx_sync ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (r_rx_sync) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // start bit is checked half a bit in; every later sample a full bit on
  always_comb begin
    w_sample = 1'b0;
    if (w_tick) begin
      if (r_state == ST_START) w_sample = (r_tcnt == HALF_LAST);
      else                     w_sample = (r_tcnt == FULL_LAST);
    end
    w_done      = (r_state == ST_STOP) && w_sample && (!r_stop2 || r_stop_idx);
    w_frame_err = r_stop_err || !r_rx_sync;
    w_break     = r_all_zero && !r_rx_sync;
    w_par_err   = par_mismatch(r_par_mode, ^r_shift, r_par_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_mode <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_stop_err <= 1'b0;
      r_all_zero <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!r_rx_sync) begin
        r_tcnt     <= '0;
        r_bcnt     <= '0;
        r_par_bit  <= 1'b0;
        r_par_mode <= (cfg_parity == 2'b11) ? PAR_NONE : parity_e'(cfg_parity);
        r_stop2    <= cfg_stop2;
        r_stop_idx <= 1'b0;
        r_stop_err <= 1'b0;
        r_all_zero <= 1'b1;
      end
    end else if (w_tick) begin
      r_tcnt <= w_sample ? '0 : r_tcnt + 1'b1;
      if (w_sample) begin
        case (r_state)
          ST_DATA: begin
            r_shift    <= {r_rx_sync, r_shift[DBIT-1:1]};
            r_bcnt     <= r_bcnt + 1'b1;
            r_all_zero <= r_all_zero & ~r_rx_sync;
          end
          ST_PARITY: begin
            r_par_bit  <= r_rx_sync;
            r_all_zero <= r_all_zero & ~r_rx_sync;
          end
          ST_STOP: begin
            r_stop_idx <= 1'b1;
            r_stop_err <= r_stop_err | ~r_rx_sync;
            r_all_zero <= r_all_zero & ~r_rx_sync;
          end
          default: r_bcnt <= r_bcnt;
        endcase
      end
    end
  end

  // a completed frame may load only if the slot is free or being drained now
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_perr  <= w_par_err;
          r_ferr  <= w_frame_err;
          r_brk   <= w_break;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_parity_err = r_perr;
  assign rx_frame_err  = r_ferr;
  assign rx_break      = r_brk;
  assign rx_overrun    = r_ovr;

endmodule
